// File: rtl/adder_pkg.sv
// Shared definitions for the adder: default word width and lookahead group size.
`ifndef WORD
`define WORD 42
`endif

package adder_pkg;

    localparam int unsigned WORD  = `WORD;
    localparam int unsigned GROUP = 4;

    // Always allocate room for bit WIDTH, so the carry out appears in the padded sum.
    function automatic int unsigned num_groups(input int unsigned width);
        return width / GROUP + 1;
    endfunction

endpackage

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead slice: bit sums plus group generate/propagate. Purely combinational.
module adder_cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       g_o,
    output logic       p_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c[0] = cin_i;
        c[1] = g[0] | (p[0] & cin_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
        sum_o = p ^ c;
        g_o   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        p_o   = &p;
    end

endmodule

// File: rtl/adder.sv
// Registered WIDTH-bit adder built from chained 4-bit lookahead groups.
// Define ADDER_FLAGS_EN to add the carry_out and overflow flag outputs.
module adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] add_out,
    output logic             out_valid
`ifdef ADDER_FLAGS_EN
    ,
    output logic             carry_out,
    output logic             overflow
`endif
);

    localparam int unsigned NumGroups = num_groups(WIDTH);
    localparam int unsigned PadW      = NumGroups * GROUP;

    logic [PadW-1:0]      a_pad;
    logic [PadW-1:0]      b_pad;
    logic [PadW-1:0]      sum_pad;
    logic [NumGroups-1:0] grp_g;
    logic [NumGroups-1:0] grp_p;
    logic [NumGroups:0]   grp_c;

    assign a_pad    = {{(PadW - WIDTH){1'b0}}, Ain};
    assign b_pad    = {{(PadW - WIDTH){1'b0}}, Bin};
    assign grp_c[0] = 1'b0;

    for (genvar i = 0; i < NumGroups; i++) begin : gen_grp
        adder_cla4 u_cla4 (
            .a_i   (a_pad[GROUP*i +: GROUP]),
            .b_i   (b_pad[GROUP*i +: GROUP]),
            .cin_i (grp_c[i]),
            .sum_o (sum_pad[GROUP*i +: GROUP]),
            .g_o   (grp_g[i]),
            .p_o   (grp_p[i])
        );
        assign grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
    end

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             valid_d, valid_q;

    always_comb begin
        sum_d   = sum_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d = sum_pad[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign add_out   = sum_q;
    assign out_valid = valid_q;

`ifdef ADDER_FLAGS_EN
    logic carry_d, carry_q;
    logic ovf_d, ovf_q;
    logic unused_top;

    // Operand padding is zero, so every padded bit from WIDTH up is zero except the carry.
    always_comb begin
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (in_valid) begin
            carry_d = |sum_pad[PadW-1:WIDTH];
            ovf_d   = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (sum_pad[WIDTH-1] != Ain[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign carry_out  = carry_q;
    assign overflow   = ovf_q;
    assign unused_top = grp_c[NumGroups];
`else
    logic unused_top;
    assign unused_top = ^{grp_c[NumGroups], sum_pad[PadW-1:WIDTH]};
`endif

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed corner cases, random back-to-back traffic, async reset.
module tb_adder;

    localparam int unsigned W = 42;
    localparam logic [63:0] M = (64'd1 << W) - 64'd1;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] Ain;
    logic [W-1:0] Bin;
    logic         in_valid;
    logic [W-1:0] add_out;
    logic         out_valid;
`ifdef ADDER_FLAGS_EN
    logic         carry_out;
    logic         overflow;
`endif

    adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Ain       (Ain),
        .Bin       (Bin),
        .in_valid  (in_valid),
        .add_out   (add_out),
        .out_valid (out_valid)
`ifdef ADDER_FLAGS_EN
        ,
        .carry_out (carry_out),
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests;
    int          fails;
    logic [63:0] exp_sum;
    logic        exp_v;
    logic        exp_c;
    logic        exp_o;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_sum"}, {22'd0, add_out}, exp_sum);
        chk({tag, "_valid"}, {63'd0, out_valid}, {63'd0, exp_v});
`ifdef ADDER_FLAGS_EN
        chk({tag, "_carry"}, {63'd0, carry_out}, {63'd0, exp_c});
        chk({tag, "_ovf"}, {63'd0, overflow}, {63'd0, exp_o});
`endif
    endtask

    // Reference: plain integer arithmetic on 64-bit values, then reduce modulo 2^W.
    task automatic step(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic v);
        logic [63:0] am;
        logic [63:0] bm;
        logic [63:0] full;
        @(negedge clk);
        Ain      = a[W-1:0];
        Bin      = b[W-1:0];
        in_valid = v;
        @(posedge clk);
        #1;
        exp_v = v;
        if (v) begin
            am      = a & M;
            bm      = b & M;
            full    = am + bm;
            exp_sum = full & M;
            exp_c   = full[W];
            exp_o   = (am[W-1] == bm[W-1]) && (exp_sum[W-1] != am[W-1]);
        end
        check_all(tag);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        exp_sum  = '0;
        exp_v    = 1'b0;
        exp_c    = 1'b0;
        exp_o    = 1'b0;
        rst_n    = 1'b0;
        Ain      = '0;
        Bin      = '0;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        step("zero", 64'd0, 64'd0, 1'b1);
        step("one_one", 64'd1, 64'd1, 1'b1);
        step("near_max", 64'd4398046511102, 64'd1, 1'b1);
        step("wrap", 64'd4398046511103, 64'd1, 1'b1);
        step("hold", 64'd123, 64'd456, 1'b0);
        step("grp_carry", 64'd1023, 64'd1, 1'b1);
        step("ovf_pos", (64'd1 << 41) - 64'd1, 64'd1, 1'b1);
        step("ovf_neg", 64'd1 << 41, 64'd1 << 41, 1'b1);
        step("neg_plus_pos", M, 64'd5, 1'b1);

        for (int i = 0; i < 60; i++) begin
            step("rand", {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset between edges, then a valid input sampled during reset.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_sum = '0;
        exp_v   = 1'b0;
        exp_c   = 1'b0;
        exp_o   = 1'b0;
        check_all("rst_async");
        @(negedge clk);
        Ain      = 42'd5;
        Bin      = 42'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_discard");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step("post_rst", 64'd7, 64'd8, 1'b1);
        step("post_rst_b2b", M, M, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter: WIDTH, default `WORD (42), operand and result width in bits.
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: Ain  input  WIDTH  unsigned/two's-complement operand A.
REQ-005 Port: Bin  input  WIDTH  unsigned/two's-complement operand B.
REQ-006 Port: in_valid  input  1  operands valid this cycle.
REQ-007 Port: add_out  output  WIDTH  registered sum, modulo 2^WIDTH.
REQ-008 Port: out_valid  output  1  add_out holds a result captured from a valid input.
REQ-009 Port (only with ADDER_FLAGS_EN): carry_out  output  1  unsigned carry out of bit WIDTH-1.
REQ-010 Port (only with ADDER_FLAGS_EN): overflow  output  1  signed two's-complement overflow.

Function
REQ-011 add_out SHALL equal (Ain + Bin) mod 2^WIDTH, registered; latency exactly 1 clock from in_valid high.
REQ-012 When in_valid is low, add_out and flags SHALL hold; out_valid SHALL go low the next cycle.
REQ-013 out_valid SHALL be in_valid delayed by one clock; there is no backpressure.
REQ-014 Wrap-around: all-ones + 1 SHALL give add_out 0 with carry_out 1; no saturation.
REQ-015 carry_out SHALL be bit WIDTH of the full-width unsigned sum.
REQ-016 overflow SHALL be 1 iff Ain[WIDTH-1]==Bin[WIDTH-1] and add_out[WIDTH-1] differs from them.
REQ-017 Carries SHALL propagate across every bit boundary, including the boundaries between lookahead groups.
REQ-018 Back-to-back valid inputs SHALL produce one result per cycle with no bubbles.

Reset
REQ-019 On rst_n low, add_out, out_valid, carry_out and overflow SHALL clear to 0 immediately, independent of clk.
REQ-020 A valid input sampled on the edge during reset SHALL be discarded; capture resumes on the first rising edge after rst_n deasserts.

Configuration
REQ-021 Macro ADDER_FLAGS_EN defined: carry_out and overflow ports and their flops SHALL exist.
REQ-022 Macro ADDER_FLAGS_EN undefined: those ports and their logic SHALL be absent; sum behaviour SHALL be unchanged.

Structure
REQ-023 `WORD and the group size constant (4) SHALL live in the shared definitions header/package.
REQ-024 The sum SHALL be built from a 4-bit carry-lookahead sub-module, adder_cla4 (generate, propagate, sum, group carry), chained with group lookahead.
REQ-025 A final partial group SHALL handle WIDTH values that are not multiples of 4; the 42-bit default has a 2-bit top group.
REQ-026 The sum output registers SHALL be in adder only; adder_cla4 SHALL be purely combinational.

Verification
REQ-027 Ain=0, Bin=0, in_valid=1 -> next cycle add_out=0, carry_out=0, out_valid=1.
REQ-028 Ain=1, Bin=1 -> add_out=2.
REQ-029 Ain=4398046511102, Bin=1 -> add_out=4398046511103, carry_out=0.
REQ-030 Ain=4398046511103, Bin=1 -> add_out=0, carry_out=1, overflow=0.
REQ-031 Ain=1023, Bin=1 -> add_out=1024 (carry across lookahead groups); Ain=2^41-1, Bin=1 -> overflow=1.
REQ-032 rst_n pulsed low mid-stream between clock edges -> all outputs 0 at once; first valid input after release produces its result one cycle later.
